uart_tx_scheduler: RTL and testbench
====================================

// Module: uart_tx_scheduler
// PURPOSE
//  Shares the single UART TX (DATA_VALID/Busy handshake) between two requesters: REQ0 (1-byte
//  register-file readback) and REQ1 (2-byte ALU result, sent low byte first). Arbitrates
//  round-robin, captures the frame, feeds bytes one at a time and waits for each TX frame to finish.
//  Sits between the system controller and UART_TX on the same clock. TX_BUSY arrives already synchronous.
// PARAMETERS
//  DATA_WIDTH    8   byte width on the TX side; REQ1 payload is 2*DATA_WIDTH
//  BUSY_TIMEOUT  8   max cycles from TX_D_VLD to TX_BUSY rising before abort (>=4)
// PORTS
//  CLK          in   1      system clock, rising edge
//  RST          in   1      synchronous reset, active-high
//  REQ0_VLD     in   1      REQ0 frame valid; held with REQ0_DATA until REQ0_ACK
//  REQ0_DATA    in   DW     REQ0 byte
//  REQ0_ACK     out  1      one-cycle pulse: REQ0 frame captured
//  REQ1_VLD     in   1      REQ1 frame valid; held with REQ1_DATA until REQ1_ACK
//  REQ1_DATA    in   2*DW   REQ1 word; [DW-1:0] sent first
//  REQ1_ACK     out  1      one-cycle pulse: REQ1 frame captured
//  TX_BUSY      in   1      UART TX Busy
//  TX_P_DATA    out  DW     byte to UART TX; stable from SEND until next SEND
//  TX_D_VLD     out  1      one-cycle DATA_VALID pulse to UART TX
//  SCH_BUSY     out  1      high whenever state != IDLE
//  TIMEOUT_ERR  out  1      sticky; set on TX_BUSY timeout
//  ERR_CLR      in   1      clears TIMEOUT_ERR (set wins if same cycle)
// BEHAVIOUR
//  - Reset: state=IDLE, all outputs 0, TX_P_DATA=0, last_grant=REQ1 (REQ0 wins first tie), timer=0.
//  - FSM states: IDLE, SEND, WAIT_BUSY, WAIT_DONE; outputs decoded from state/registers only.
//  - IDLE: grant only when TX_BUSY=0 and any VLD. Single VLD -> that requester; both -> the one not
//    in last_grant; update last_grant. On the grant edge capture data into a 2*DW buffer, load
//    bytes_left (REQ0:1, REQ1:2), go SEND. TX_BUSY=1 in IDLE blocks grants (no error).
//  - SEND (1 cycle): TX_D_VLD=1, TX_P_DATA=buffer[DW-1:0]; granted REQx_ACK=1 only on first SEND
//    of a frame. Clear timer, decrement bytes_left, shift buffer right by DW -> WAIT_BUSY.
//    Latency: VLD sampled at edge k -> ACK and TX_D_VLD high in cycle k+1.
//  - WAIT_BUSY: TX_BUSY=1 -> WAIT_DONE. Else timer++; at timer==BUSY_TIMEOUT-1: set
//    TIMEOUT_ERR, discard remaining bytes, -> IDLE (no retry).
//  - WAIT_DONE: hold until TX_BUSY=0; then bytes_left!=0 -> SEND (high byte), else -> IDLE.
//    No timeout here; frame length is bounded by UART TX itself.
//  - Requester dropping VLD before ACK: not captured (only sampled in IDLE). VLD re-asserted
//    the cycle after ACK is a new frame, arbitrated on next IDLE.
//  - TX_BUSY glitching low in WAIT_BUSY before rising: ignored (only rise matters).
//  - RST mid-frame: immediate return to reset values next edge; partial frame dropped, no ACK.
//  - Timer width $clog2(BUSY_TIMEOUT); no wrap reachable.
// STRUCTURE
//  - Shared package: state encodings (one-hot, 4 bits), REQ0/REQ1 grant ids, byte-count constants.
//  - One sub-module: rr_arbiter2 (2 requests, enable, last_grant reg, one-hot grant out).
//  - Rest (FSM, capture buffer, bytes_left, timer, error flag) in this module.
// TESTING
//  1. REQ0_VLD=1, DATA=8'hA5, TX model raises Busy 2 cycles after DATA_VALID for 11 cycles ->
//     one TX_D_VLD with 8'hA5, REQ0_ACK 1 cycle same cycle, SCH_BUSY drops after Busy falls.
//  2. REQ1 DATA=16'h3C7E -> TX_D_VLD twice: 8'h7E then 8'h3C, second only after Busy low; 1 ACK.
//  3. Both VLD held continuously, 3 frames each -> grant order REQ0,REQ1,REQ0,REQ1,REQ0,REQ1.
//  4. TX model never raises Busy, BUSY_TIMEOUT=8 -> TIMEOUT_ERR set 8 cycles after SEND, REQ1 high
//     byte never sent, IDLE; ERR_CLR pulse clears it; next REQ0 served normally.
//  5. RST pulse during WAIT_DONE of REQ1 low byte -> all outputs 0 next cycle, high byte not sent,
//     next tie goes to REQ0.
//  6. TX_BUSY forced high while REQ0_VLD=1 in IDLE -> no ACK/TX_D_VLD until TX_BUSY=0, then +1 cycle.

Source files
------------

// File: rtl/uart_tx_scheduler_pkg.sv
// Shared definitions for the UART TX scheduler: FSM encoding, grant ids,
// per-requester frame lengths and a grant decode helper.
package uart_tx_scheduler_pkg;

  // One-hot scheduler states
  typedef enum logic [3:0] {
    ST_IDLE      = 4'b0001,
    ST_SEND      = 4'b0010,
    ST_WAIT_BUSY = 4'b0100,
    ST_WAIT_DONE = 4'b1000
  } sched_state_t;

  // Requester identifiers
  typedef enum logic {
    GNT_REQ0 = 1'b0,
    GNT_REQ1 = 1'b1
  } grant_id_t;

  // Bytes per frame for each requester
  localparam logic [1:0] BYTES_NONE = 2'd0;
  localparam logic [1:0] BYTES_REQ0 = 2'd1;
  localparam logic [1:0] BYTES_REQ1 = 2'd2;

  // Convert a one-hot grant vector into a requester id
  function automatic grant_id_t onehot_to_id(input logic [1:0] grant);
    return (grant == 2'b10) ? GNT_REQ1 : GNT_REQ0;
  endfunction

endpackage

// File: rtl/uart_tx_scheduler_rr_arbiter2.sv
// Two-way round-robin arbiter. A tie goes to the requester that was not
// granted last; the remembered winner only moves when a grant is issued.
module rr_arbiter2
  import uart_tx_scheduler_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       en,
  input  logic [1:0] req,
  output logic [1:0] grant
);

  grant_id_t last_grant_r;

  // Combinational grant selection from requests and the last winner
  always_comb begin
    grant = 2'b00;
    if (!en) begin
      grant = 2'b00;
    end else if (req == 2'b11) begin
      grant = (last_grant_r == GNT_REQ1) ? 2'b01 : 2'b10;
    end else begin
      grant = req;
    end
  end

  // Remember the most recent winner; REQ1 after reset so REQ0 wins the first tie
  always_ff @(posedge clk) begin
    if (rst) begin
      last_grant_r <= GNT_REQ1;
    end else if (grant != 2'b00) begin
      last_grant_r <= onehot_to_id(grant);
    end else begin
      last_grant_r <= last_grant_r;
    end
  end

endmodule

// File: rtl/uart_tx_scheduler.sv
// Shares one UART transmitter between a 1-byte requester (REQ0) and a
// 2-byte requester (REQ1, low byte first). Frames are captured on grant,
// fed byte by byte, and each byte waits for the transmitter Busy cycle.
module uart_tx_scheduler
  import uart_tx_scheduler_pkg::*;
#(
  parameter int DATA_WIDTH   = 8,
  parameter int BUSY_TIMEOUT = 8
) (
  input  logic                    CLK,
  input  logic                    RST,
  input  logic                    REQ0_VLD,
  input  logic [DATA_WIDTH-1:0]   REQ0_DATA,
  output logic                    REQ0_ACK,
  input  logic                    REQ1_VLD,
  input  logic [2*DATA_WIDTH-1:0] REQ1_DATA,
  output logic                    REQ1_ACK,
  input  logic                    TX_BUSY,
  output logic [DATA_WIDTH-1:0]   TX_P_DATA,
  output logic                    TX_D_VLD,
  output logic                    SCH_BUSY,
  output logic                    TIMEOUT_ERR,
  input  logic                    ERR_CLR
);

  localparam int TIMER_W = $clog2(BUSY_TIMEOUT);
  localparam logic [TIMER_W-1:0] TIMER_LAST = TIMER_W'(BUSY_TIMEOUT - 1);

  sched_state_t              state_r;
  logic [2*DATA_WIDTH-1:0]   buffer_r;
  logic [1:0]                bytes_left_r;
  logic [TIMER_W-1:0]        timer_r;
  grant_id_t                 gnt_id_r;
  logic                      first_r;
  logic [DATA_WIDTH-1:0]     tx_p_data_r;
  logic                      err_r;

  logic                      arb_en_s;
  logic [1:0]                grant_s;
  logic [2*DATA_WIDTH-1:0]   capture_s;
  logic                      timeout_hit_s;

  // Grants are only considered in IDLE with the transmitter free
  assign arb_en_s = (state_r == ST_IDLE) && !TX_BUSY;

  rr_arbiter2 u_arb (
    .clk   (CLK),
    .rst   (RST),
    .en    (arb_en_s),
    .req   ({REQ1_VLD, REQ0_VLD}),
    .grant (grant_s)
  );

  // Select the frame payload of the granted requester
  always_comb begin
    capture_s = '0;
    if (grant_s[1]) begin
      capture_s = REQ1_DATA;
    end else if (grant_s[0]) begin
      capture_s = {{DATA_WIDTH{1'b0}}, REQ0_DATA};
    end else begin
      capture_s = '0;
    end
  end

  // Busy never rose within the allowed window
  assign timeout_hit_s = (state_r == ST_WAIT_BUSY) && !TX_BUSY && (timer_r == TIMER_LAST);

  // Scheduler FSM with capture buffer, byte count and Busy timer
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_r      <= ST_IDLE;
      buffer_r     <= '0;
      bytes_left_r <= BYTES_NONE;
      timer_r      <= '0;
      gnt_id_r     <= GNT_REQ0;
      first_r      <= 1'b0;
      tx_p_data_r  <= '0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (grant_s != 2'b00) begin
            buffer_r     <= capture_s;
            tx_p_data_r  <= capture_s[DATA_WIDTH-1:0];
            bytes_left_r <= grant_s[1] ? BYTES_REQ1 : BYTES_REQ0;
            gnt_id_r     <= onehot_to_id(grant_s);
            first_r      <= 1'b1;
            state_r      <= ST_SEND;
          end
        end
        ST_SEND: begin
          first_r      <= 1'b0;
          timer_r      <= '0;
          bytes_left_r <= bytes_left_r - 2'd1;
          buffer_r     <= buffer_r >> DATA_WIDTH;
          state_r      <= ST_WAIT_BUSY;
        end
        ST_WAIT_BUSY: begin
          if (TX_BUSY) begin
            state_r <= ST_WAIT_DONE;
          end else if (timer_r == TIMER_LAST) begin
            // Abort the frame: remaining bytes are dropped, no retry
            bytes_left_r <= BYTES_NONE;
            buffer_r     <= '0;
            state_r      <= ST_IDLE;
          end else begin
            timer_r <= timer_r + TIMER_W'(1);
          end
        end
        ST_WAIT_DONE: begin
          if (!TX_BUSY) begin
            if (bytes_left_r != BYTES_NONE) begin
              tx_p_data_r <= buffer_r[DATA_WIDTH-1:0];
              state_r     <= ST_SEND;
            end else begin
              state_r <= ST_IDLE;
            end
          end
        end
        default: begin
          state_r <= ST_IDLE;
        end
      endcase
    end
  end

  // Sticky timeout flag; a new timeout beats a simultaneous clear
  always_ff @(posedge CLK) begin
    if (RST) begin
      err_r <= 1'b0;
    end else if (timeout_hit_s) begin
      err_r <= 1'b1;
    end else if (ERR_CLR) begin
      err_r <= 1'b0;
    end else begin
      err_r <= err_r;
    end
  end

  // Outputs decoded from registered state only
  assign TX_D_VLD    = (state_r == ST_SEND);
  assign REQ0_ACK    = (state_r == ST_SEND) && first_r && (gnt_id_r == GNT_REQ0);
  assign REQ1_ACK    = (state_r == ST_SEND) && first_r && (gnt_id_r == GNT_REQ1);
  assign TX_P_DATA   = tx_p_data_r;
  assign SCH_BUSY    = (state_r != ST_IDLE);
  assign TIMEOUT_ERR = err_r;

endmodule

// File: tb/tb_uart_tx_scheduler.sv
// Scoreboard bench for uart_tx_scheduler: a transaction-level round-robin
// model predicts ACK order and transmitted bytes; a monitor checks them.
module tb_uart_tx_scheduler;

  localparam int DW = 8;
  localparam int BT = 8;

  logic          CLK;
  logic          RST;
  logic          REQ0_VLD;
  logic [DW-1:0] REQ0_DATA;
  logic          REQ0_ACK;
  logic          REQ1_VLD;
  logic [2*DW-1:0] REQ1_DATA;
  logic          REQ1_ACK;
  logic          TX_BUSY;
  logic [DW-1:0] TX_P_DATA;
  logic          TX_D_VLD;
  logic          SCH_BUSY;
  logic          TIMEOUT_ERR;
  logic          ERR_CLR;

  logic tx_force;
  logic tx_busy_m;
  int   tx_mode;   // 0 normal model, 1 never raise Busy, 2 model off
  bit   tx_fixed;

  int n_checks = 0;
  int n_pass   = 0;
  int model_last;
  logic [7:0]  exp_bytes[$];
  int          exp_ack[$];
  logic [7:0]  q0_frames[$];
  logic [15:0] q1_frames[$];

  assign TX_BUSY = tx_force | tx_busy_m;

  uart_tx_scheduler #(.DATA_WIDTH(DW), .BUSY_TIMEOUT(BT)) dut (
    .CLK(CLK), .RST(RST),
    .REQ0_VLD(REQ0_VLD), .REQ0_DATA(REQ0_DATA), .REQ0_ACK(REQ0_ACK),
    .REQ1_VLD(REQ1_VLD), .REQ1_DATA(REQ1_DATA), .REQ1_ACK(REQ1_ACK),
    .TX_BUSY(TX_BUSY), .TX_P_DATA(TX_P_DATA), .TX_D_VLD(TX_D_VLD),
    .SCH_BUSY(SCH_BUSY), .TIMEOUT_ERR(TIMEOUT_ERR), .ERR_CLR(ERR_CLR)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic check(input bit ok, input string name, input longint act, input longint req);
    n_checks++;
    if (ok) n_pass++;
    else $display("FAIL %s: actual=%0h required=%0h", name, act, req);
  endtask

  // UART TX model: Busy rises dly cycles after DATA_VALID and lasts len cycles
  initial begin
    int dly;
    int len;
    tx_busy_m = 1'b0;
    forever begin
      @(negedge CLK);
      if (TX_D_VLD === 1'b1 && tx_mode == 0) begin
        dly = tx_fixed ? 2 : int'($urandom_range(1, 3));
        len = tx_fixed ? 11 : int'($urandom_range(3, 11));
        repeat (dly) @(posedge CLK);
        #1 tx_busy_m = 1'b1;
        repeat (len) @(posedge CLK);
        #1 tx_busy_m = 1'b0;
      end
    end
  end

  // Monitor: compare every ACK and every sent byte against the scoreboard
  initial begin
    int ea;
    logic [7:0] eb;
    forever begin
      @(negedge CLK);
      if (REQ0_ACK === 1'b1 || REQ1_ACK === 1'b1) begin
        if (exp_ack.size() == 0) begin
          check(1'b0, "ack_unexpected", {REQ1_ACK, REQ0_ACK}, 0);
        end else begin
          ea = exp_ack.pop_front();
          check((REQ1_ACK === (ea == 1)) && (REQ0_ACK === (ea == 0)) && TX_D_VLD === 1'b1,
                "ack_order", {REQ1_ACK, REQ0_ACK}, (ea == 1) ? 2 : 1);
        end
      end
      if (TX_D_VLD === 1'b1) begin
        check(TX_BUSY === 1'b0, "send_while_busy", TX_BUSY, 0);
        if (exp_bytes.size() == 0) begin
          check(1'b0, "byte_unexpected", TX_P_DATA, 0);
        end else begin
          eb = exp_bytes.pop_front();
          check(TX_P_DATA === eb, "tx_byte", TX_P_DATA, eb);
        end
      end
    end
  end

  task automatic wait_idle();
    int k = 0;
    do begin @(negedge CLK); k++; end while ((SCH_BUSY !== 1'b0 || TX_BUSY !== 1'b0) && k < 400);
    check(k < 400, "idle_wait", k, 400);
  endtask

  task automatic drive0();
    for (int i = 0; i < q0_frames.size(); i++) begin
      int k = 0;
      REQ0_DATA = q0_frames[i];
      REQ0_VLD  = 1'b1;
      do begin @(negedge CLK); k++; end while (REQ0_ACK !== 1'b1 && k < 400);
      check(REQ0_ACK === 1'b1, "req0_ack_wait", REQ0_ACK, 1);
    end
    REQ0_VLD = 1'b0;
  endtask

  task automatic drive1();
    for (int i = 0; i < q1_frames.size(); i++) begin
      int k = 0;
      REQ1_DATA = q1_frames[i];
      REQ1_VLD  = 1'b1;
      do begin @(negedge CLK); k++; end while (REQ1_ACK !== 1'b1 && k < 400);
      check(REQ1_ACK === 1'b1, "req1_ack_wait", REQ1_ACK, 1);
    end
    REQ1_VLD = 1'b0;
  endtask

  // Reference model: both pending -> the one not granted last; else the pending one
  task automatic run_round();
    int r0 = q0_frames.size();
    int r1 = q1_frames.size();
    int i0 = 0;
    int i1 = 0;
    int pick;
    while (r0 > 0 || r1 > 0) begin
      if (r0 > 0 && r1 > 0) pick = (model_last == 0) ? 1 : 0;
      else                  pick = (r0 > 0) ? 0 : 1;
      model_last = pick;
      exp_ack.push_back(pick);
      if (pick == 0) begin
        exp_bytes.push_back(q0_frames[i0]);
        i0++; r0--;
      end else begin
        exp_bytes.push_back(q1_frames[i1] % 256);
        exp_bytes.push_back(q1_frames[i1] / 256);
        i1++; r1--;
      end
    end
    fork
      drive0();
      drive1();
    join
    wait_idle();
    q0_frames.delete();
    q1_frames.delete();
  endtask

  task automatic watch_busy_drop();
    int k = 0;
    do begin @(negedge CLK); k++; end while (TX_BUSY !== 1'b1 && k < 100);
    do begin @(negedge CLK); k++; end while (TX_BUSY !== 1'b0 && k < 200);
    check(SCH_BUSY === 1'b1, "sch_busy_hold", SCH_BUSY, 1);
    @(negedge CLK);
    check(SCH_BUSY === 1'b0, "sch_busy_drop", SCH_BUSY, 0);
  endtask

  task automatic watch_timeout();
    int k = 0;
    int cnt = 0;
    do begin @(negedge CLK); k++; end while (TX_D_VLD !== 1'b1 && k < 100);
    check(k < 100, "timeout_send_wait", k, 100);
    do begin @(negedge CLK); cnt++; end while (TIMEOUT_ERR !== 1'b1 && cnt < 40);
    // 8 cycles waiting with timer 0..7, flag visible the cycle after
    check(cnt == BT + 1, "timeout_latency", cnt, BT + 1);
    check(SCH_BUSY === 1'b0, "timeout_idle", SCH_BUSY, 0);
    if (exp_bytes.size() > 0) void'(exp_bytes.pop_back());
  endtask

  task automatic inject_reset();
    int k = 0;
    do begin @(negedge CLK); k++; end while (TX_BUSY !== 1'b1 && k < 100);
    check(k < 100, "rst_busy_wait", k, 100);
    @(negedge CLK);
    RST = 1'b1;
    @(negedge CLK);
    check({REQ0_ACK, REQ1_ACK, TX_D_VLD, SCH_BUSY, TIMEOUT_ERR, TX_P_DATA} === 13'd0,
          "midframe_reset", {REQ0_ACK, REQ1_ACK, TX_D_VLD, SCH_BUSY, TIMEOUT_ERR, TX_P_DATA}, 0);
    RST = 1'b0;
    if (exp_bytes.size() > 0) void'(exp_bytes.pop_back());
    model_last = 1;
  endtask

  initial begin
    logic [7:0] d;
    int n0;
    int n1;
    int k;
    RST = 1'b1; REQ0_VLD = 1'b0; REQ1_VLD = 1'b0; REQ0_DATA = '0; REQ1_DATA = '0;
    ERR_CLR = 1'b0; tx_force = 1'b0; tx_mode = 0; tx_fixed = 1'b0; model_last = 1;
    repeat (3) @(negedge CLK);
    check(REQ0_ACK === 1'b0, "rst_req0_ack", REQ0_ACK, 0);
    check(REQ1_ACK === 1'b0, "rst_req1_ack", REQ1_ACK, 0);
    check(TX_D_VLD === 1'b0, "rst_tx_d_vld", TX_D_VLD, 0);
    check(SCH_BUSY === 1'b0, "rst_sch_busy", SCH_BUSY, 0);
    check(TIMEOUT_ERR === 1'b0, "rst_timeout_err", TIMEOUT_ERR, 0);
    check(TX_P_DATA === 8'h00, "rst_tx_p_data", TX_P_DATA, 0);
    RST = 1'b0;
    @(negedge CLK);

    // Single REQ0 byte, Busy 2 cycles after DATA_VALID for 11 cycles
    tx_fixed = 1'b1;
    q0_frames.push_back(8'hA5);
    fork
      run_round();
      watch_busy_drop();
    join
    tx_fixed = 1'b0;

    // REQ1 word sent low byte first
    q1_frames.push_back(16'h3C7E);
    run_round();

    // Both held for three frames each: strict alternation from REQ0
    for (int i = 0; i < 3; i++) begin
      q0_frames.push_back(8'($urandom));
      q1_frames.push_back(16'($urandom));
    end
    run_round();

    // Busy never rises: timeout, high byte dropped, flag sticky until cleared
    tx_mode = 1;
    q1_frames.push_back(16'($urandom));
    fork
      run_round();
      watch_timeout();
    join
    tx_mode = 0;
    repeat (3) @(negedge CLK);
    check(TIMEOUT_ERR === 1'b1, "timeout_sticky", TIMEOUT_ERR, 1);
    ERR_CLR = 1'b1;
    @(negedge CLK);
    ERR_CLR = 1'b0;
    check(TIMEOUT_ERR === 1'b0, "err_clear", TIMEOUT_ERR, 0);
    q0_frames.push_back(8'($urandom));
    run_round();

    // Reset while waiting for the low byte to finish
    q1_frames.push_back(16'($urandom));
    fork
      run_round();
      inject_reset();
    join
    q0_frames.push_back(8'($urandom));
    q1_frames.push_back(16'($urandom));
    run_round();

    // Busy held high in IDLE blocks the grant; ACK one cycle after release
    tx_mode  = 2;
    tx_force = 1'b1;
    d = 8'($urandom);
    exp_ack.push_back(0);
    exp_bytes.push_back(d);
    model_last = 0;
    REQ0_DATA = d;
    REQ0_VLD  = 1'b1;
    k = 0;
    repeat (5) begin
      @(negedge CLK);
      if (REQ0_ACK !== 1'b0 || TX_D_VLD !== 1'b0) k++;
    end
    check(k == 0, "busy_blocks_grant", k, 0);
    tx_force = 1'b0;
    tx_mode  = 0;
    @(negedge CLK);
    check(REQ0_ACK === 1'b1, "grant_after_busy", REQ0_ACK, 1);
    REQ0_VLD = 1'b0;
    wait_idle();

    // Randomized rounds
    for (int r = 0; r < 20; r++) begin
      n0 = int'($urandom_range(0, 3));
      n1 = int'($urandom_range(0, 3));
      if (n0 == 0 && n1 == 0) n0 = 1;
      for (int i = 0; i < n0; i++) q0_frames.push_back(8'($urandom));
      for (int i = 0; i < n1; i++) q1_frames.push_back(16'($urandom));
      run_round();
    end

    repeat (5) @(negedge CLK);
    check(exp_bytes.size() == 0, "bytes_left_over", exp_bytes.size(), 0);
    check(exp_ack.size() == 0, "acks_left_over", exp_ack.size(), 0);
    check(TIMEOUT_ERR === 1'b0, "final_err", TIMEOUT_ERR, 0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
